final_design: RTL and testbench

- Minimal 16-bit single-cycle processor with program-load and run modes.
- Host writes 16-bit instructions into an internal 256-word instruction memory (IMEM), then starts execution from address 0.
- Internal state: 16x16 register file (RF) and 256x16 data memory (DMEM).
- Debug read ports expose RF and DMEM contents to the bench and top level.

---
 rtl/final_design.sv | 134 +++++++++++++
 tb/tb_final_design.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/final_design.sv
// Minimal 16-bit single-cycle processor: host loads IMEM, then runs from address 0 until HALT or pc passes last loaded address.
// Latency: one instruction per clock in RUN; state/pc/RF/DMEM update on the same edge. No backpressure: valid is a plain command.
module final_design #(
    parameter int DATA_W     = 16,
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256,
    parameter int RF_DEPTH   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        valid,
    input  logic [DATA_W-1:0] instruction,
    input  logic [7:0]        instruction_address,
    output logic [7:0]        pc,
    output logic              running,
    output logic              done,
    input  logic [3:0]        dbg_rf_sel,
    output logic [DATA_W-1:0] dbg_rf_data,
    input  logic [7:0]        dbg_dmem_sel,
    output logic [DATA_W-1:0] dbg_dmem_data
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_LOADC = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_JZ    = 4'b0101;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    logic [DATA_W-1:0] imem [IMEM_DEPTH];
    logic [DATA_W-1:0] dmem [DMEM_DEPTH];
    logic [DATA_W-1:0] rf   [RF_DEPTH];

    state_t      state, state_nxt;
    logic [7:0]  pc_nxt;
    logic        prog_valid;
    logic [7:0]  last_addr;

    logic [DATA_W-1:0] instr;
    logic [3:0]        op, ra, rb, rc;
    logic [7:0]        imm;

    logic              im_we, rf_we, dm_we, seq_step;
    logic [DATA_W-1:0] rf_wd;

    assign instr = imem[pc];
    assign op    = instr[15:12];
    assign ra    = instr[11:8];
    assign rb    = instr[7:4];
    assign rc    = instr[3:0];
    assign imm   = instr[7:0];

    assign running       = (state == S_RUN);
    assign done          = (state == S_DONE);
    assign dbg_rf_data   = rf[dbg_rf_sel];
    assign dbg_dmem_data = dmem[dbg_dmem_sel];

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        im_we     = 1'b0;
        rf_we     = 1'b0;
        dm_we     = 1'b0;
        rf_wd     = '0;
        seq_step  = 1'b1;
        case (state)
            S_IDLE, S_DONE: begin
                if (valid == 2'b01) begin
                    im_we     = 1'b1;
                    state_nxt = S_IDLE;
                end else if (valid == 2'b11) begin
                    pc_nxt    = 8'd0;
                    state_nxt = prog_valid ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                pc_nxt = pc + 8'd1;
                case (op)
                    OP_LOAD:  begin rf_we = 1'b1; rf_wd = dmem[imm]; end
                    OP_STORE: dm_we = 1'b1;
                    OP_ADD:   begin rf_we = 1'b1; rf_wd = rf[rb] + rf[rc]; end
                    OP_LOADC: begin rf_we = 1'b1; rf_wd = {8'h00, imm}; end
                    OP_SUB:   begin rf_we = 1'b1; rf_wd = rf[rb] - rf[rc]; end
                    OP_JZ: begin
                        if (rf[ra] == '0) begin
                            // 8-bit add of the raw imm equals pc + sext(imm) mod 256
                            pc_nxt   = pc + imm;
                            seq_step = 1'b0;
                        end
                    end
                    OP_HALT: begin
                        pc_nxt   = pc;
                        seq_step = 1'b0;
                    end
                    default: ;
                endcase
                // sequential wrap from 255 to 0 also ends the program
                if (op == OP_HALT || pc_nxt > last_addr || (seq_step && pc == 8'hFF))
                    state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc         <= 8'd0;
            prog_valid <= 1'b0;
            last_addr  <= 8'd0;
            for (int i = 0; i < RF_DEPTH; i++)   rf[i]   <= '0;
            for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (im_we) begin
                prog_valid <= 1'b1;
                if (!prog_valid || instruction_address > last_addr)
                    last_addr <= instruction_address;
            end
            if (rf_we) rf[ra]   <= rf_wd;
            if (dm_we) dmem[imm] <= rf[ra];
        end
    end

    // program store survives reset
    always_ff @(posedge clk) begin
        if (im_we) imem[instruction_address] <= instruction;
    end

endmodule

// File: tb/tb_final_design.sv
// Directed bench for final_design: loads small programs, runs them, checks pc trace, status and RF/DMEM via debug ports.
module tb_final_design;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  valid;
    logic [15:0] instruction;
    logic [7:0]  instruction_address;
    logic [7:0]  pc;
    logic        running, done;
    logic [3:0]  dbg_rf_sel;
    logic [15:0] dbg_rf_data;
    logic [7:0]  dbg_dmem_sel;
    logic [15:0] dbg_dmem_data;

    int checks = 0;
    int errors = 0;

    final_design dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .instruction(instruction),
        .instruction_address(instruction_address), .pc(pc), .running(running), .done(done),
        .dbg_rf_sel(dbg_rf_sel), .dbg_rf_data(dbg_rf_data),
        .dbg_dmem_sel(dbg_dmem_sel), .dbg_dmem_data(dbg_dmem_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        valid = 2'b00;
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        step();
    endtask

    task automatic load(input logic [7:0] a, input logic [15:0] w);
        valid = 2'b01;
        instruction_address = a;
        instruction = w;
        step();
        valid = 2'b00;
    endtask

    task automatic start();
        valid = 2'b11;
        step();
        valid = 2'b00;
    endtask

    // runs until done with a cycle budget; returns executed-cycle count
    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (!done && cyc < budget) begin
            step();
            cyc++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL wait_done: done=%0b after %0d cycles, required 1", done, cyc);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (pc !== 8'd0 || running !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: pc=%0d running=%0b done=%0b, required 0/0/0", pc, running, done);
        end
        start();
        checks++;
        if (done !== 1'b1 || pc !== 8'd0 || running !== 1'b0) begin
            errors++;
            $display("FAIL run_no_prog: done=%0b pc=%0d running=%0b, required 1/0/0", done, pc, running);
        end
        for (int r = 0; r < 16; r++) begin
            dbg_rf_sel = 4'(r);
            #1;
            checks++;
            if (dbg_rf_data !== 16'h0) begin
                errors++;
                $display("FAIL reset_rf%0d: got %h, required 0000", r, dbg_rf_data);
            end
        end
    endtask

    task automatic load_main(input logic [15:0] w6);
        load(8'd0, 16'h3001); load(8'd0, 16'h3001); load(8'd1, 16'h1000);
        load(8'd2, 16'h3102); load(8'd3, 16'h1101); load(8'd4, 16'h0200);
        load(8'd5, 16'h2321); load(8'd6, w6);       load(8'd7, 16'h5502);
        load(8'd8, 16'h3000); load(8'd9, 16'h4423);
    endtask

    task automatic test_main_program();
        logic [7:0]  exp_pc [9]  = '{0, 1, 2, 3, 4, 5, 6, 7, 9};
        logic [15:0] exp_rf [6]  = '{16'h1, 16'h2, 16'h1, 16'h3, 16'hFFFE, 16'h0};
        do_reset();
        load_main(16'h3500);
        start();
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (running !== 1'b1 || pc !== exp_pc[i]) begin
                errors++;
                $display("FAIL main_pc[%0d]: pc=%0d running=%0b, required pc=%0d running=1", i, pc, running, exp_pc[i]);
            end
            step();
        end
        checks++;
        if (done !== 1'b1 || running !== 1'b0) begin
            errors++;
            $display("FAIL main_done: done=%0b running=%0b, required 1/0", done, running);
        end
        for (int r = 0; r < 6; r++) begin
            dbg_rf_sel = 4'(r);
            #1;
            checks++;
            if (dbg_rf_data !== exp_rf[r]) begin
                errors++;
                $display("FAIL main_rf%0d: got %h, required %h", r, dbg_rf_data, exp_rf[r]);
            end
        end
        for (int m = 0; m < 2; m++) begin
            dbg_dmem_sel = 8'(m);
            #1;
            checks++;
            if (dbg_dmem_data !== 16'(m + 1)) begin
                errors++;
                $display("FAIL main_dmem%0d: got %h, required %h", m, dbg_dmem_data, 16'(m + 1));
            end
        end
        // restart from DONE keeps RF and re-executes the same program
        start();
        checks++;
        if (running !== 1'b1 || pc !== 8'd0) begin
            errors++;
            $display("FAIL restart: running=%0b pc=%0d, required 1/0", running, pc);
        end
        begin
            int cyc;
            wait_done(20, cyc);
        end
    endtask

    task automatic test_jz_not_taken();
        int cyc;
        do_reset();
        load_main(16'h3501);
        start();
        wait_done(30, cyc);
        checks++;
        if (cyc !== 10) begin
            errors++;
            $display("FAIL jz_nt_cycles: got %0d, required 10", cyc);
        end
        dbg_rf_sel = 4'd0;
        #1;
        checks++;
        if (dbg_rf_data !== 16'h0) begin
            errors++;
            $display("FAIL jz_nt_rf0: got %h, required 0000", dbg_rf_data);
        end
        dbg_rf_sel = 4'd5;
        #1;
        checks++;
        if (dbg_rf_data !== 16'h1) begin
            errors++;
            $display("FAIL jz_nt_rf5: got %h, required 0001", dbg_rf_data);
        end
    endtask

    task automatic test_jz_backward();
        logic [7:0] exp_pc [4] = '{0, 1, 4, 2};
        do_reset();
        load(8'd0, 16'h3000); load(8'd1, 16'h5003); load(8'd2, 16'hF000);
        load(8'd3, 16'h0000); load(8'd4, 16'h50FE);
        start();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (running !== 1'b1 || pc !== exp_pc[i]) begin
                errors++;
                $display("FAIL jzb_pc[%0d]: pc=%0d running=%0b, required pc=%0d running=1", i, pc, running, exp_pc[i]);
            end
            step();
        end
        checks++;
        if (done !== 1'b1 || pc !== 8'd2) begin
            errors++;
            $display("FAIL halt_pc: done=%0b pc=%0d, required 1/2", done, pc);
        end
        // wrap: pc=1, imm=FD -> 254, which is beyond last_addr
        do_reset();
        load(8'd0, 16'h3000); load(8'd1, 16'h50FD);
        start();
        step();
        step();
        checks++;
        if (pc !== 8'd254 || done !== 1'b1) begin
            errors++;
            $display("FAIL jz_wrap: pc=%0d done=%0b, required 254/1", pc, done);
        end
    endtask

    task automatic test_overflow();
        int cyc;
        logic [3:0]  sel [4] = '{4'd1, 4'd3, 4'd7, 4'd2};
        logic [15:0] exp [4] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0001};
        do_reset();
        load(8'd0, 16'h3355); load(8'd1, 16'h3000); load(8'd2, 16'h3201);
        load(8'd3, 16'h4102); load(8'd4, 16'h2312); load(8'd5, 16'h3801);
        load(8'd6, 16'h3902); load(8'd7, 16'h4789); load(8'd8, 16'hF000);
        start();
        wait_done(30, cyc);
        checks++;
        if (pc !== 8'd8 || cyc !== 9) begin
            errors++;
            $display("FAIL ovf_halt: pc=%0d cycles=%0d, required 8/9", pc, cyc);
        end
        for (int i = 0; i < 4; i++) begin
            dbg_rf_sel = sel[i];
            #1;
            checks++;
            if (dbg_rf_data !== exp[i]) begin
                errors++;
                $display("FAIL ovf_rf%0d: got %h, required %h", sel[i], dbg_rf_data, exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        load(8'd0, 16'h3001); load(8'd1, 16'h1000); load(8'd2, 16'h3107);
        load(8'd3, 16'h3000); load(8'd4, 16'h5000);
        start();
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (running !== 1'b1 || pc !== 8'd4) begin
            errors++;
            $display("FAIL loop_running: running=%0b pc=%0d, required 1/4", running, pc);
        end
        #2 rst_n = 1'b0;
        #1;
        dbg_rf_sel   = 4'd1;
        dbg_dmem_sel = 8'd0;
        #1;
        checks++;
        if (pc !== 8'd0 || running !== 1'b0 || dbg_rf_data !== 16'h0 || dbg_dmem_data !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset: pc=%0d running=%0b rf1=%h dmem0=%h, required 0/0/0000/0000",
                     pc, running, dbg_rf_data, dbg_dmem_data);
        end
        rst_n = 1'b1;
        step();
        start();
        checks++;
        if (done !== 1'b1 || running !== 1'b0) begin
            errors++;
            $display("FAIL run_after_reset: done=%0b running=%0b, required 1/0", done, running);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        valid = 2'b00;
        instruction = '0;
        instruction_address = '0;
        dbg_rf_sel = '0;
        dbg_dmem_sel = '0;
        test_reset();
        test_main_program();
        test_jz_not_taken();
        test_jz_backward();
        test_overflow();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
